// File: rtl/spi_frame_rx.sv
// SPI receive front-end: oversamples SCLK/COPI/CS_N in the clk domain and
// deserialises DATA_W-bit words into a valid/ready stream. It reports
// frame completion, dropped words, aborts and inter-edge timeouts.
module spi_frame_rx #(
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FRAME_LEN   = 113,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 10000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sclk,
    input  logic                           copi,
    input  logic                           cs_n,
    input  logic                           rx_enable,
    output logic [DATA_W-1:0]              rx_data,
    output logic                           rx_valid,
    input  logic                           rx_ready,
    output logic                           rx_last,
    output logic [$clog2(FRAME_LEN+1)-1:0] word_idx,
    output logic                           overflow,
    output logic                           frame_done,
    output logic                           frame_err,
    output logic [1:0]                     err_code
);

    localparam int unsigned WIDX_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned BIT_W  = $clog2(DATA_W);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CS
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        sclk_s, cs_s, copi_s;
    logic [1:0]        primed_q;
    logic              primed;
    logic              lead_edge, trail_edge, sample_edge;
    logic              cs_fall, cs_rise;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              tmo_full;
    logic              done_ok;

    logic              start, abort, tmo_hit, shift_en, word_done, frame_end, close_ok;
    logic              last_word;

    // Three-flop synchronisers; primed_q masks CS edges until the chain has
    // flushed its reset value, so CS already low at reset exit never starts a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s   <= {3{CPOL}};
            cs_s     <= '1;
            copi_s   <= '0;
            primed_q <= '0;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            cs_s   <= {cs_s[1:0], cs_n};
            copi_s <= {copi_s[1:0], copi};
            if (primed_q != 2'd3) begin
                primed_q <= primed_q + 2'd1;
            end
        end
    end

    // Edge detection between synchroniser stages 2 and 3, plus shift-path data.
    always_comb begin
        primed      = (primed_q == 2'd3);
        lead_edge   = (sclk_s[2] == CPOL) && (sclk_s[1] != CPOL);
        trail_edge  = (sclk_s[2] != CPOL) && (sclk_s[1] == CPOL);
        sample_edge = CPHA ? trail_edge : lead_edge;
        cs_fall     = primed && cs_s[2] && !cs_s[1];
        cs_rise     = primed && !cs_s[2] && cs_s[1];
        tmo_full    = (tmo_cnt == TMO_W'(TIMEOUT_CYC));
        last_word   = (word_idx == WIDX_W'(FRAME_LEN - 1));
        if (MSB_FIRST) begin
            shift_d = {shift_q[DATA_W-2:0], copi_s[2]};
        end else begin
            shift_d = {copi_s[2], shift_q[DATA_W-1:1]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM control strobes; abort outranks timeout, which outranks a sample edge.
    always_comb begin
        start     = 1'b0;
        abort     = 1'b0;
        tmo_hit   = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
        close_ok  = 1'b0;
        case (state_q)
            IDLE: begin
                start = cs_fall && rx_enable;
            end
            SHIFT: begin
                if (cs_rise) begin
                    abort = 1'b1;
                end else if (tmo_full) begin
                    tmo_hit = 1'b1;
                end else if (sample_edge) begin
                    shift_en  = 1'b1;
                    word_done = (bit_cnt == BIT_W'(DATA_W - 1));
                end
            end
            WAIT_CS: begin
                close_ok = cs_rise && done_ok;
            end
            default: begin
            end
        endcase
        frame_end = word_done && last_word;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tmo_hit || frame_end) begin
                    state_d = WAIT_CS;
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame bookkeeping: shifter, bit/word counters, timeout, status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            word_idx   <= '0;
            tmo_cnt    <= '0;
            done_ok    <= 1'b0;
            err_code   <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= close_ok;
            frame_err  <= abort || tmo_hit;
            if (start) begin
                bit_cnt  <= '0;
                word_idx <= '0;
                err_code <= 2'b00;
                done_ok  <= 1'b0;
            end
            if (abort) begin
                err_code <= 2'b01;
            end
            if (tmo_hit) begin
                err_code <= 2'b10;
                done_ok  <= 1'b0;
            end
            if (start || shift_en) begin
                tmo_cnt <= '0;
            end else if (state_q == SHIFT && !tmo_full) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (shift_en) begin
                shift_q <= shift_d;
                bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
            end
            if (word_done) begin
                word_idx <= word_idx + WIDX_W'(1);
            end
            if (frame_end) begin
                done_ok <= 1'b1;
            end
        end
    end

    // Output register, independent of the FSM so a pending word survives
    // abort, timeout and return to IDLE; a completed word that finds it full
    // and not being drained this cycle is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_last  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (start) begin
                overflow <= 1'b0;
            end
            if (word_done && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_d;
                rx_valid <= 1'b1;
                rx_last  <= last_word;
            end else begin
                if (word_done) begin
                    overflow <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                    rx_last  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: one mode-0 MSB-first instance (4-word
// frames, 50-cycle timeout) plus single-word LSB-first instances in modes 1-3.
module tb_spi_frame_rx;

    localparam int H = 5;  // clk cycles per SCLK half-period

    logic       clk, rst_n, copi, rx_enable, rx_ready;
    logic       sclk0, cs0;
    logic       sclk1, sclk2, sclk3, cs1, cs2, cs3;

    logic [7:0] d0_data;
    logic       d0_valid, d0_last, d0_ovf, d0_done, d0_err;
    logic [2:0] d0_widx;
    logic [1:0] d0_code;

    logic [7:0] m_data [1:3];
    logic       m_valid[1:3];
    logic       m_last [1:3];
    logic       m_widx [1:3];
    logic       m_ovf  [1:3];
    logic       m_done [1:3];
    logic       m_err  [1:3];
    logic [1:0] m_code [1:3];

    int         n_cmp = 0;
    int         n_mis = 0;
    int         done0 = 0;
    int         err0  = 0;
    int         mdone[1:3];
    int         merr [1:3];
    logic [8:0] cap_q[$];

    spi_frame_rx #(
        .CPOL(1'b0), .CPHA(1'b0), .DATA_W(8), .FRAME_LEN(4),
        .MSB_FIRST(1'b1), .TIMEOUT_CYC(50)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .copi(copi), .cs_n(cs0),
        .rx_enable(rx_enable), .rx_data(d0_data), .rx_valid(d0_valid),
        .rx_ready(rx_ready), .rx_last(d0_last), .word_idx(d0_widx),
        .overflow(d0_ovf), .frame_done(d0_done), .frame_err(d0_err),
        .err_code(d0_code)
    );

    spi_frame_rx #(
        .CPOL(1'b0), .CPHA(1'b1), .DATA_W(8), .FRAME_LEN(1), .MSB_FIRST(1'b0)
    ) u_mode1 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk1), .copi(copi), .cs_n(cs1),
        .rx_enable(rx_enable), .rx_data(m_data[1]), .rx_valid(m_valid[1]),
        .rx_ready(rx_ready), .rx_last(m_last[1]), .word_idx(m_widx[1]),
        .overflow(m_ovf[1]), .frame_done(m_done[1]), .frame_err(m_err[1]),
        .err_code(m_code[1])
    );

    spi_frame_rx #(
        .CPOL(1'b1), .CPHA(1'b0), .DATA_W(8), .FRAME_LEN(1), .MSB_FIRST(1'b0)
    ) u_mode2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk2), .copi(copi), .cs_n(cs2),
        .rx_enable(rx_enable), .rx_data(m_data[2]), .rx_valid(m_valid[2]),
        .rx_ready(rx_ready), .rx_last(m_last[2]), .word_idx(m_widx[2]),
        .overflow(m_ovf[2]), .frame_done(m_done[2]), .frame_err(m_err[2]),
        .err_code(m_code[2])
    );

    spi_frame_rx #(
        .CPOL(1'b1), .CPHA(1'b1), .DATA_W(8), .FRAME_LEN(1), .MSB_FIRST(1'b0)
    ) u_mode3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk3), .copi(copi), .cs_n(cs3),
        .rx_enable(rx_enable), .rx_data(m_data[3]), .rx_valid(m_valid[3]),
        .rx_ready(rx_ready), .rx_last(m_last[3]), .word_idx(m_widx[3]),
        .overflow(m_ovf[3]), .frame_done(m_done[3]), .frame_err(m_err[3]),
        .err_code(m_code[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on the falling edge, record beats that will handshake on the
    // next rising edge and count status pulse cycles.
    initial begin
        for (int i = 1; i <= 3; i++) begin
            mdone[i] = 0;
            merr[i]  = 0;
        end
    end
    always @(negedge clk) begin
        if (d0_valid && rx_ready) cap_q.push_back({d0_last, d0_data});
        if (d0_done) done0++;
        if (d0_err) err0++;
        for (int i = 1; i <= 3; i++) begin
            if (m_done[i]) mdone[i]++;
            if (m_err[i]) merr[i]++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_sclk(input int sel, input logic v);
        case (sel)
            0: sclk0 = v;
            1: sclk1 = v;
            2: sclk2 = v;
            default: sclk3 = v;
        endcase
    endtask

    task automatic spi_bit(input int sel, input logic cpol, input logic cpha, input logic b);
        if (!cpha) begin
            copi = b;
            cyc(H);
            set_sclk(sel, ~cpol);
            cyc(H);
            set_sclk(sel, cpol);
        end else begin
            set_sclk(sel, ~cpol);
            copi = b;
            cyc(H);
            set_sclk(sel, cpol);
            cyc(H);
        end
    endtask

    task automatic spi_word(input int sel, input logic cpol, input logic cpha,
                            input logic msb, input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            spi_bit(sel, cpol, cpha, msb ? w[7-i] : w[i]);
        end
    endtask

    task automatic frame0(input logic [31:0] words);
        cs0 = 1'b0;
        cyc(H);
        for (int i = 0; i < 4; i++) begin
            spi_word(0, 1'b0, 1'b0, 1'b1, words[31-8*i -: 8]);
        end
        cyc(H);
        cs0 = 1'b1;
        cyc(10);
    endtask

    initial begin
        int b, bd, be;
        logic [7:0] ev [4];

        rst_n = 1'b0; copi = 1'b0; rx_enable = 1'b1; rx_ready = 1'b1;
        sclk0 = 1'b0; sclk1 = 1'b0; sclk2 = 1'b1; sclk3 = 1'b1;
        cs0 = 1'b1; cs1 = 1'b1; cs2 = 1'b1; cs3 = 1'b1;

        // Reset values
        cyc(3);
        check("rst_data", d0_data, 8'h00);
        check("rst_valid", d0_valid, 1'b0);
        check("rst_last", d0_last, 1'b0);
        check("rst_widx", d0_widx, 3'd0);
        check("rst_ovf", d0_ovf, 1'b0);
        check("rst_done", d0_done, 1'b0);
        check("rst_err", d0_err, 1'b0);
        check("rst_code", d0_code, 2'b00);
        rst_n = 1'b1;
        cyc(5);

        // Mode 0 frame A5 3C FF 00, consumer always ready
        b = cap_q.size(); bd = done0; be = err0;
        frame0(32'hA53CFF00);
        ev[0] = 8'hA5; ev[1] = 8'h3C; ev[2] = 8'hFF; ev[3] = 8'h00;
        check("f1_beats", cap_q.size() - b, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f1_beat%0d", i), cap_q[b+i], {(i == 3), ev[i]});
        end
        check("f1_done", done0 - bd, 1);
        check("f1_err", err0 - be, 0);
        check("f1_ovf", d0_ovf, 1'b0);
        check("f1_widx", d0_widx, 3'd4);
        check("f1_valid", d0_valid, 1'b0);
        check("f1_code", d0_code, 2'b00);

        // Consumer stalled for the whole frame
        rx_ready = 1'b0;
        b = cap_q.size(); bd = done0;
        frame0(32'h11223344);
        check("ovf_data", d0_data, 8'h11);
        check("ovf_valid", d0_valid, 1'b1);
        check("ovf_last", d0_last, 1'b0);
        check("ovf_flag", d0_ovf, 1'b1);
        check("ovf_widx", d0_widx, 3'd4);
        check("ovf_done", done0 - bd, 1);
        rx_ready = 1'b1;
        cyc(1);
        check("ovf_drain_valid", d0_valid, 1'b0);
        check("ovf_drain_beat", cap_q[b], {1'b0, 8'h11});
        check("ovf_drain_cnt", cap_q.size() - b, 1);

        // Abort after two words and three bits
        b = cap_q.size(); bd = done0; be = err0;
        cs0 = 1'b0;
        cyc(H);
        spi_word(0, 1'b0, 1'b0, 1'b1, 8'h12);
        spi_word(0, 1'b0, 1'b0, 1'b1, 8'h34);
        spi_bit(0, 1'b0, 1'b0, 1'b1);
        spi_bit(0, 1'b0, 1'b0, 1'b0);
        spi_bit(0, 1'b0, 1'b0, 1'b1);
        cyc(H);
        cs0 = 1'b1;
        cyc(10);
        check("abt_err", err0 - be, 1);
        check("abt_code", d0_code, 2'b01);
        check("abt_done", done0 - bd, 0);
        check("abt_beats", cap_q.size() - b, 2);
        check("abt_beat1", cap_q[b+1], {1'b0, 8'h34});
        check("abt_widx", d0_widx, 3'd2);

        // Timeout: SCLK stalls mid-word; a new frame start clears err_code
        b = cap_q.size(); bd = done0; be = err0;
        cs0 = 1'b0;
        cyc(H);
        check("tmo_start_code", d0_code, 2'b00);
        check("tmo_start_widx", d0_widx, 3'd0);
        spi_bit(0, 1'b0, 1'b0, 1'b1);
        spi_bit(0, 1'b0, 1'b0, 1'b1);
        spi_bit(0, 1'b0, 1'b0, 1'b0);
        cyc(40);
        check("tmo_early_code", d0_code, 2'b00);
        check("tmo_early_err", err0 - be, 0);
        cyc(20);
        check("tmo_code", d0_code, 2'b10);
        check("tmo_err", err0 - be, 1);
        for (int i = 0; i < 5; i++) spi_bit(0, 1'b0, 1'b0, 1'b1);
        cyc(H);
        cs0 = 1'b1;
        cyc(10);
        check("tmo_done", done0 - bd, 0);
        check("tmo_err_once", err0 - be, 1);
        check("tmo_beats", cap_q.size() - b, 0);
        check("tmo_code_held", d0_code, 2'b10);

        // Reset mid-frame with CS held low
        cs0 = 1'b0;
        cyc(H);
        for (int i = 0; i < 4; i++) spi_bit(0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        cyc(2);
        check("mrst_valid", d0_valid, 1'b0);
        check("mrst_widx", d0_widx, 3'd0);
        check("mrst_code", d0_code, 2'b00);
        rst_n = 1'b1;
        cyc(5);
        b = cap_q.size(); bd = done0; be = err0;
        for (int i = 0; i < 4; i++) spi_word(0, 1'b0, 1'b0, 1'b1, 8'hC3);
        cyc(10);
        check("mrst_nobeats", cap_q.size() - b, 0);
        check("mrst_nowidx", d0_widx, 3'd0);
        check("mrst_nodone", done0 - bd, 0);
        cs0 = 1'b1;
        cyc(H);
        frame0(32'h5A01807E);
        check("mrst_beats", cap_q.size() - b, 4);
        check("mrst_beat0", cap_q[b], {1'b0, 8'h5A});
        check("mrst_beat3", cap_q[b+3], {1'b1, 8'h7E});
        check("mrst_done", done0 - bd, 1);
        check("mrst_err", err0 - be, 0);

        // Modes 1..3, LSB first, single-word frames of A5
        for (int m = 1; m <= 3; m++) begin
            bd = mdone[m]; be = merr[m];
            case (m)
                1: cs1 = 1'b0;
                2: cs2 = 1'b0;
                default: cs3 = 1'b0;
            endcase
            cyc(H);
            spi_word(m, (m >= 2), (m != 2), 1'b0, 8'hA5);
            cyc(H);
            case (m)
                1: cs1 = 1'b1;
                2: cs2 = 1'b1;
                default: cs3 = 1'b1;
            endcase
            cyc(10);
            check($sformatf("mode%0d_data", m), m_data[m], 8'hA5);
            check($sformatf("mode%0d_done", m), mdone[m] - bd, 1);
            check($sformatf("mode%0d_err", m), merr[m] - be, 0);
            check($sformatf("mode%0d_widx", m), m_widx[m], 1'b1);
            check($sformatf("mode%0d_ovf", m), m_ovf[m], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_frame_rx.md
# spi_frame_rx

Parametrised SPI receive front-end for the OCR accelerator: oversamples SCLK/COPI/CS_N in the system clock domain, deserialises DATA_W-bit words in any SPI mode and bit order, and delivers them over a valid/ready stream with frame-boundary, overflow, abort and timeout reporting. It sits between the external SPI pins and the image-buffer/BNN loader. It adds backpressure-aware output buffering and per-edge timeout to the existing fixed 8-bit receiver.

## Interface
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- DATA_W, 8: bits per word (2..32).
- FRAME_LEN, 113: words per frame (≥1); word counter width $clog2(FRAME_LEN+1).
- MSB_FIRST, 1: 1 = first bit lands in rx_data[DATA_W-1], 0 = in rx_data[0].
- TIMEOUT_CYC, 10000: max clk cycles between sample edges inside a frame.
- clk  in  1  system clock; reset rst_n, asynchronous, active-low; clock clk.
- rst_n  in  1  asynchronous active-low reset.
- sclk, copi, cs_n  in  1 each  raw SPI pins (cs_n active-low).
- rx_enable  in  1  arms reception; sampled only at frame start.
- rx_data  out  DATA_W  received word.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts word when rx_valid && rx_ready.
- rx_last  out  1  qualifies rx_data as word FRAME_LEN-1 of frame.
- word_idx  out  $clog2(FRAME_LEN+1)  words completed in current frame.
- overflow  out  1  sticky: a word was dropped this frame.
- frame_done  out  1  one-cycle pulse: complete frame closed by CS deassert.
- frame_err  out  1  one-cycle pulse on abort or timeout.
- err_code  out  2  01 = abort, 10 = timeout; held until next frame start.

## Operation
- Sync: 3-flop chains on sclk (reset CPOL), cs_n (reset 1), copi (reset 0). Edges detected between stages 2 and 3; leading edge = stage-3 level equals CPOL and stage-2 differs; trailing is the converse. COPI taken from stage 3.
- FSM states: IDLE, SHIFT, WAIT_CS.
- IDLE: enter SHIFT on synced CS falling edge with rx_enable=1; clear bit_cnt, word_idx, overflow, err_code, timeout counter. CS already low at reset exit or when rx_enable rises mid-transfer does not start a frame.
- SHIFT: each sample edge shifts one bit (direction per MSB_FIRST), clears timeout counter. On DATA_W-th bit: word completes, bit_cnt←0, word_idx+1.
- Word completion: if output register empty, or being accepted that same cycle, load it, rx_valid←1, rx_last←(word_idx==FRAME_LEN-1). Otherwise drop word, set overflow; word_idx still increments.
- After word FRAME_LEN-1 completes → WAIT_CS; further SCLK edges ignored.
- CS deasserts in SHIFT → frame_err, err_code=01, → IDLE. Timeout counter reaching TIMEOUT_CYC in SHIFT → frame_err, err_code=10, → WAIT_CS.
- WAIT_CS: on synced CS rising edge → IDLE; pulse frame_done only if entered by frame completion.
- rx_valid clears on handshake; output register independent of FSM, so a pending word survives abort/timeout/IDLE.
- rx_enable deassertion mid-frame has no effect.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_last=0, word_idx=0, overflow=0, frame_done=0, frame_err=0, err_code=00; FSM IDLE.
- Latency: final sample edge captured into sync stage 1 at clk edge N → rx_valid high after clk edge N+2.
- CS deassert captured at edge N → frame_done/frame_err high for exactly cycle after edge N+2.
- Timeout counter saturates; timeout and CS deassert same cycle → abort wins.
- Max SCLK = clk/8; COPI must be stable ≥3 clk cycles around sample edge.
- Simultaneous word completion and handshake → no overflow, new word valid next cycle.
- Reset mid-frame: all state cleared immediately; frame in progress discarded.

## Test plan
- Mode 0, DATA_W=8, FRAME_LEN=4, rx_ready=1, send A5 3C FF 00 → four rx_valid beats with those values, rx_last on 00, frame_done once after CS high, overflow=0.
- Modes 1/2/3 and MSB_FIRST=0, send A5 → rx_data=A5 (LSB-first sender) in all modes.
- rx_ready=0 for whole frame of 4 → rx_data holds first word, overflow=1, word_idx=4, frame_done still pulses.
- CS high after 2 words + 3 bits → frame_err, err_code=01, FSM IDLE, no frame_done.
- TIMEOUT_CYC=50, SCLK stalled 60 cycles mid-word → frame_err, err_code=10 at cycle 50, frame_done suppressed at later CS high.
- rst_n pulsed mid-frame with CS held low, then clocking resumes → no words output until CS toggles high then low.
